// File: rtl/instr_cache.sv
// instr_cache: direct-mapped, one-word-per-line instruction cache between iq and the memory fetcher
// Ports: clk; rst (sync, active-high); is_exception_from_rob aborts any in-flight request.
//   iq side: is_request_from_iq/pc_from_iq in, is_hit_to_iq/instr_to_iq out.
//   fc side: is_request_to_fc/addr_to_fc out, is_done_from_fc/instr_from_fc in.
// Define ICACHE_STAT_EN to add the hit_count_out/miss_count_out statistics ports.
module instr_cache #(
  parameter int IndexWidth = 5,
  parameter int TagWidth = 32 - IndexWidth - 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_exception_from_rob,
  input  logic        is_request_from_iq,
  input  logic [31:0] pc_from_iq,
  output logic        is_hit_to_iq,
  output logic [31:0] instr_to_iq,
  output logic        is_request_to_fc,
  output logic [31:0] addr_to_fc,
  input  logic        is_done_from_fc,
`ifdef ICACHE_STAT_EN
  output logic [31:0] hit_count_out,
  output logic [31:0] miss_count_out,
`endif
  input  logic [31:0] instr_from_fc
);
  localparam int Lines = 2 ** IndexWidth;
  typedef enum logic [1:0] {IDLE, MISS, HOLD} state_t;
  state_t state;
  logic [Lines-1:0] valid;
  logic [TagWidth-1:0] tags [Lines];
  logic [31:0] data [Lines];
  logic [31:2] req_pc;
  logic [IndexWidth-1:0] idx, req_idx;
  logic lookup_hit;
  logic unused_pc_bits;
  assign unused_pc_bits = ^pc_from_iq[1:0];
  assign idx = pc_from_iq[IndexWidth+1:2];
  assign req_idx = req_pc[IndexWidth+1:2];
  assign lookup_hit = valid[idx] && tags[idx] == pc_from_iq[31:IndexWidth+2];
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      is_hit_to_iq <= 1'b0;
      instr_to_iq <= '0;
      is_request_to_fc <= 1'b0;
      addr_to_fc <= '0;
`ifdef ICACHE_STAT_EN
      hit_count_out <= '0;
      miss_count_out <= '0;
`endif
    end else if (is_exception_from_rob) begin
      state <= IDLE;
      is_hit_to_iq <= 1'b0;
      is_request_to_fc <= 1'b0;
    end else begin
      case (state)
        IDLE: if (is_request_from_iq) begin
          req_pc <= pc_from_iq[31:2];
          state <= lookup_hit ? HOLD : MISS;
          is_hit_to_iq <= lookup_hit;
          is_request_to_fc <= !lookup_hit;
          if (lookup_hit) instr_to_iq <= data[idx];
          else addr_to_fc <= {pc_from_iq[31:2], 2'b00};
`ifdef ICACHE_STAT_EN
          hit_count_out <= hit_count_out + 32'(lookup_hit);
          miss_count_out <= miss_count_out + 32'(!lookup_hit);
`endif
        end
        MISS: if (is_done_from_fc) begin
          data[req_idx] <= instr_from_fc;
          tags[req_idx] <= req_pc[31:IndexWidth+2];
          valid[req_idx] <= 1'b1;
          is_request_to_fc <= 1'b0;
          is_hit_to_iq <= 1'b1;
          instr_to_iq <= instr_from_fc;
          state <= HOLD;
        end
        default: begin
          // one idle cycle lets iq advance its pc before the next lookup
          is_hit_to_iq <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: table-driven, scoreboarded bench for instr_cache
module tb_instr_cache;
  logic clk = 1'b0;
  logic rst, exc, req, done;
  logic [31:0] pc, fill;
  logic is_hit_to_iq, is_request_to_fc;
  logic [31:0] instr_to_iq, addr_to_fc;
`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif
  always #5 clk = ~clk;
  instr_cache dut (
    .clk(clk),
    .rst(rst),
    .is_exception_from_rob(exc),
    .is_request_from_iq(req),
    .pc_from_iq(pc),
    .is_hit_to_iq(is_hit_to_iq),
    .instr_to_iq(instr_to_iq),
    .is_request_to_fc(is_request_to_fc),
    .addr_to_fc(addr_to_fc),
    .is_done_from_fc(done),
`ifdef ICACHE_STAT_EN
    .hit_count_out(hit_cnt),
    .miss_count_out(miss_cnt),
`endif
    .instr_from_fc(fill)
  );
  typedef struct {
    logic [31:0] pc;
    logic [31:0] fill;
    bit miss;
    logic [31:0] instr;
    int lat;
  } vec_t;
  vec_t vecs[10];
  logic [31:0] sb[$];
  int total = 0, bad = 0, exp_hits = 0, exp_misses = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (is_hit_to_iq === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got instr=%h want=no pulse", instr_to_iq);
      end else chk("response_instr", instr_to_iq, sb.pop_front());
    end
  end
  task automatic do_req(input vec_t v);
    @(negedge clk);
    req = 1'b1;
    pc = v.pc;
    sb.push_back(v.instr);
    if (v.miss) exp_misses++;
    else exp_hits++;
    @(negedge clk);
    req = 1'b0;
    chk("hit_latency", 32'(is_hit_to_iq), 32'(!v.miss));
    chk("fc_request", 32'(is_request_to_fc), 32'(v.miss));
    if (v.miss) begin
      chk("fc_addr", addr_to_fc, {v.pc[31:2], 2'b00});
      for (int i = 0; i < v.lat; i++) begin
        @(negedge clk);
        chk("fc_request_held", 32'(is_request_to_fc), 1);
      end
      done = 1'b1;
      fill = v.fill;
      @(negedge clk);
      done = 1'b0;
      chk("fill_pulse", 32'(is_hit_to_iq), 1);
      chk("fc_request_drop", 32'(is_request_to_fc), 0);
    end
    chk("pending_responses", sb.size(), 0);
    @(negedge clk);
    chk("pulse_end", 32'(is_hit_to_iq), 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_hit", 32'(is_hit_to_iq), 0);
    chk("rst_instr", instr_to_iq, 0);
    chk("rst_fc_req", 32'(is_request_to_fc), 0);
    chk("rst_addr", addr_to_fc, 0);
`ifdef ICACHE_STAT_EN
    chk("rst_hit_count", hit_cnt, 0);
    chk("rst_miss_count", miss_cnt, 0);
`endif
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask
  initial begin
    rst = 1'b1;
    exc = 1'b0;
    req = 1'b0;
    done = 1'b0;
    pc = '0;
    fill = '0;
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 1'b1, 32'h0000_0013, 0};
    vecs[1] = '{32'h0000_0000, 32'h0, 1'b0, 32'h0000_0013, 0};
    vecs[2] = '{32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1};
    vecs[3] = '{32'h0000_0000, 32'h0000_0093, 1'b1, 32'h0000_0093, 2};
    vecs[4] = '{32'h0000_0084, 32'h1111_1111, 1'b1, 32'h1111_1111, 0};
    vecs[5] = '{32'h0000_0086, 32'h0, 1'b0, 32'h1111_1111, 0};
    vecs[6] = '{32'h0000_0000, 32'h0, 1'b0, 32'h0000_0093, 0};
    vecs[7] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 3};
    vecs[8] = '{32'hFFFF_FFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 0};
    vecs[9] = '{32'h0000_007C, 32'h1234_5678, 1'b1, 32'h1234_5678, 1};
    do_reset();
    for (int i = 0; i < 4; i++) do_req(vecs[i]);
`ifdef ICACHE_STAT_EN
    chk("stat_hits_t1_3", hit_cnt, 1);
    chk("stat_misses_t1_3", miss_cnt, 3);
`endif
    for (int i = 4; i < 10; i++) do_req(vecs[i]);
    // exception during MISS with a fill in the same cycle
    @(negedge clk);
    req = 1'b1;
    pc = 32'h0000_0080;
    exp_misses++;
    @(negedge clk);
    req = 1'b0;
    chk("exc_miss_fc_req", 32'(is_request_to_fc), 1);
    exc = 1'b1;
    done = 1'b1;
    fill = 32'hBAD0_BAD0;
    @(negedge clk);
    exc = 1'b0;
    done = 1'b0;
    chk("exc_no_pulse", 32'(is_hit_to_iq), 0);
    chk("exc_fc_req_drop", 32'(is_request_to_fc), 0);
    @(negedge clk);
    chk("exc_idle_quiet", 32'(is_request_to_fc), 0);
    do_req('{32'h0000_0080, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 0});
    // request coinciding with an exception is not accepted
    @(negedge clk);
    exc = 1'b1;
    req = 1'b1;
    pc = 32'h0000_0080;
    @(negedge clk);
    exc = 1'b0;
    req = 1'b0;
    chk("exc_req_no_hit", 32'(is_hit_to_iq), 0);
    chk("exc_req_no_fc", 32'(is_request_to_fc), 0);
    // stray fill while idle must not write the array
    done = 1'b1;
    fill = 32'h5555_5555;
    @(negedge clk);
    done = 1'b0;
    chk("stray_done_no_pulse", 32'(is_hit_to_iq), 0);
    do_req('{32'h0000_0080, 32'h0, 1'b0, 32'hDEAD_BEEF, 0});
    // request held high through HOLD: one pulse per accept, re-accept two cycles later
    @(negedge clk);
    req = 1'b1;
    pc = 32'h0000_0080;
    sb.push_back(32'hDEAD_BEEF);
    exp_hits++;
    @(negedge clk);
    chk("held_pulse1", 32'(is_hit_to_iq), 1);
    sb.push_back(32'hDEAD_BEEF);
    exp_hits++;
    @(negedge clk);
    chk("held_hold_gap", 32'(is_hit_to_iq), 0);
    @(negedge clk);
    chk("held_pulse2", 32'(is_hit_to_iq), 1);
    req = 1'b0;
    @(negedge clk);
    chk("held_end", 32'(is_hit_to_iq), 0);
    chk("held_pending", sb.size(), 0);
`ifdef ICACHE_STAT_EN
    chk("stat_hits_final", hit_cnt, exp_hits);
    chk("stat_misses_final", miss_cnt, exp_misses);
`endif
    // reset clears valid bits: previously cached pc misses again
    do_reset();
    do_req('{32'h0000_0000, 32'h0000_0013, 1'b1, 32'h0000_0013, 0});
`ifdef ICACHE_STAT_EN
    chk("stat_misses_after_rst", miss_cnt, exp_misses);
`endif
    chk("final_pending", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
